// File: rtl/relu_stream_ctrl.sv
// Streaming ReLU over IEEE-style sign/exponent/mantissa words with job control.
// Single registered output stage gives one-cycle latency and full 1/cycle throughput.
module relu_stream_ctrl #(
    parameter int unsigned I_EXP  = 8,
    parameter int unsigned I_MNT  = 23,
    parameter int unsigned I_DATA = I_EXP + I_MNT + 1,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [I_DATA-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [I_DATA-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  neg_cnt
);

    localparam int unsigned SignBit = I_DATA - 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
    logic [LEN_W-1:0]  neg_cnt_q, neg_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [I_DATA-1:0] out_data_q, out_data_d;

    logic start_acc;
    logic in_xfer;
    logic out_xfer;
    logic last_out;
    logic stage_free;

    assign start_acc  = (state_q == StIdle) & start;
    assign stage_free = ~out_valid_q | out_ready;
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid_q & out_ready;
    // len_q >= 1 whenever RUN is entered, so len_q - 1 never underflows here
    assign last_out   = out_xfer & (out_cnt_q == (len_q - LEN_W'(1)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_out) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        in_ready = (state_q == StRun) & (in_cnt_q < len_q) & stage_free;
    end

    // Counters and output stage next-state
    always_comb begin
        len_d       = len_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        neg_cnt_d   = neg_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (start_acc) begin
            len_d     = len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            neg_cnt_d = '0;
        end else begin
            if (in_xfer) begin
                in_cnt_d = in_cnt_q + LEN_W'(1);
                if (in_data[SignBit]) begin
                    neg_cnt_d = neg_cnt_q + LEN_W'(1);
                end
            end
            if (out_xfer) begin
                out_cnt_d = out_cnt_q + LEN_W'(1);
            end
        end

        // A new element overwrites the stage in the same cycle the old one leaves
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[SignBit] ? '0 : in_data;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            neg_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            len_q       <= len_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            neg_cnt_q   <= neg_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign neg_cnt   = neg_cnt_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Scoreboard bench for relu_stream_ctrl: a job of length L consumes the first L offered
// elements; each expected result is queued at issue and popped by an output monitor.
module tb_relu_stream_ctrl;

    localparam int W  = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [LW-1:0] neg_cnt;

    relu_stream_ctrl #(
        .I_EXP (8),
        .I_MNT (23),
        .I_DATA(W),
        .LEN_W (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .neg_cnt  (neg_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [W-1:0] exp_q[$];
    int xfer_cnt, done_cnt, first_xfer, last_xfer, done_cyc;
    bit job_end, abort;
    bit saw_in_ready, saw_out_valid;
    int rdy_mode = 0;
    bit prev_stall = 1'b0;
    logic [W-1:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: negative sign yields zero, otherwise the word is passed through
    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] x);
        return x[W-1] ? '0 : x;
    endfunction

    function automatic logic [W-1:0] rand_elem();
        logic [W-1:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v = {v[31], 8'hFF, 23'h0};
            1: v = {v[31], 8'hFF, v[22:0] | 23'h400000};
            2: v = {v[31], 31'h0};
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
                if (xfer_cnt == 0) first_xfer = cyc;
                last_xfer = cyc;
                xfer_cnt++;
            end
            if (in_ready) saw_in_ready = 1'b1;
            if (out_valid) saw_out_valid = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                job_end = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic pulse_start(input int l);
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] el[$], input int l, input bit rand_valid,
                         output int acc);
        int  idx = 0;
        int  budget = 0;
        bit  accepted;
        while (idx < el.size() && !job_end && !abort && budget < 2000) begin
            in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = el[idx];
            @(negedge clk);
            if (budget == 0) chk("busy_in_run", busy, 1);
            if (idx == l) chk("in_ready_after_len", in_ready, 0);
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) idx++;
            budget++;
        end
        in_valid = 1'b0;
        acc = idx;
    endtask

    // ctl: 0 none, 1 re-issue start with len=9 mid-job, 2 stall out_ready 3 cycles
    task automatic run_job(input int l, input logic [W-1:0] el[$], input bit rand_valid,
                           input int mode, input int ctl, input string tag);
        int acc = 0;
        int nneg = 0;
        int t = 0;
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(relu_ref(el[i]));
            if (el[i][W-1]) nneg++;
        end
        xfer_cnt = 0;
        done_cnt = 0;
        job_end  = 1'b0;
        abort    = 1'b0;
        rdy_mode = mode;
        if (mode == 2) out_ready = 1'b1;
        pulse_start(l);
        fork
            drive(el, l, rand_valid, acc);
            begin
                if (ctl == 1 && busy) begin
                    start = 1'b1;
                    len   = LW'(9);
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end else if (ctl == 2) begin
                    int w = 0;
                    while (xfer_cnt < 2 && w < 100) begin
                        @(posedge clk);
                        #1;
                        w++;
                    end
                    out_ready = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk({tag, "_stall_in_ready"}, in_ready, 0);
                        chk({tag, "_stall_valid"}, out_valid, 1);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                end
            end
        join
        while (!job_end && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, job_end, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_consumed"}, acc, l);
        chk({tag, "_outputs"}, xfer_cnt, l);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_latency"}, done_cyc, last_xfer + 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_neg_cnt"}, neg_cnt, nneg);
        chk({tag, "_busy_end"}, busy, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] el[$];
        int acc;
        int w;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_neg_cnt", neg_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Special values, full throughput
        el = '{32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFFC00000};
        run_job(4, el, 1'b0, 0, 0, "basic");
        chk("basic_one_per_cycle", last_xfer - first_xfer, 3);

        // Downstream stall
        el.delete();
        for (int i = 0; i < 6; i++) el.push_back(rand_elem());
        run_job(6, el, 1'b0, 2, 2, "stall");

        // Zero-length job; previous job left neg_cnt possibly nonzero
        el = '{32'h80000000, 32'h3F800000};
        run_job(2, el, 1'b0, 0, 0, "preload");
        done_cnt = 0;
        saw_in_ready = 1'b0;
        saw_out_valid = 1'b0;
        pulse_start(0);
        @(negedge clk);
        chk("len0_done_next", done, 1);
        chk("len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("len0_done_count", done_cnt, 1);
        chk("len0_in_ready_seen", saw_in_ready, 0);
        chk("len0_out_valid_seen", saw_out_valid, 0);
        chk("len0_neg_cnt", neg_cnt, 0);
        @(posedge clk);
        #1;

        // Start re-issued during RUN is ignored
        el = '{32'hC0000000, 32'h40490FDB};
        run_job(2, el, 1'b0, 0, 1, "restart");

        // Upstream offers more than len
        el.delete();
        for (int i = 0; i < 6; i++) el.push_back(rand_elem());
        run_job(4, el, 1'b0, 0, 0, "overrun");

        // Reset mid-job after 2 of 5 outputs
        el.delete();
        for (int i = 0; i < 5; i++) el.push_back(32'hBF800000 ^ (i << 30));
        for (int i = 0; i < 5; i++) exp_q.push_back(relu_ref(el[i]));
        xfer_cnt = 0;
        done_cnt = 0;
        job_end  = 1'b0;
        abort    = 1'b0;
        rdy_mode = 0;
        pulse_start(5);
        fork
            drive(el, 5, 1'b0, acc);
            begin
                w = 0;
                while (xfer_cnt < 2 && w < 100) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                #2;
                rst   = 1'b1;
                abort = 1'b1;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_out_data", out_data, 0);
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_neg_cnt", neg_cnt, 0);
                chk("abort_done", done, 0);
            end
        join
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        el = '{32'h80000000};
        run_job(1, el, 1'b0, 0, 0, "after_rst");

        // Randomised jobs
        for (int j = 0; j < 25; j++) begin
            int l;
            l = $urandom_range(1, 12);
            el.delete();
            for (int i = 0; i < l + int'($urandom_range(0, 2)); i++) el.push_back(rand_elem());
            run_job(l, el, 1'b1, 1, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
